hx711_multi_reader: RTL and testbench

Parametrised HX711 load-cell ADC front end that reads NCH converters sharing one PD_SCK line, each with its own DOUT. It detects data-ready on all channels, shifts out 24-bit two's-complement samples MSB first and appends 1–3 gain/channel-select pulses. It presents the samples with a one-cycle valid strobe. It supersedes the single-channel fixed-gain HX711 reader in the scale datapath and feeds the display/averaging logic downstream.

---
 rtl/hx711_multi_reader_if.sv | 15 +
 rtl/hx711_multi_reader.sv | 146 ++++++++++++++
 tb/tb_hx711_multi_reader.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hx711_multi_reader_if.sv
// Host-side control and sample bus of hx711_multi_reader: the reader is the slave,
// the consumer of the samples (display/averaging logic) is the master.
interface hx711_multi_reader_if #(
  parameter int NCH = 2
);
  logic                en;
  logic [1:0]          gain_sel;
  logic [24*NCH-1:0]   data_out;
  logic                valid;
  logic                busy;
  logic                timeout;

  modport master (output en, gain_sel, input data_out, valid, busy, timeout);
  modport slave  (input en, gain_sel, output data_out, valid, busy, timeout);
endinterface

// File: rtl/hx711_multi_reader.sv
// Lock-step reader for NCH HX711 ADCs sharing one PD_SCK line.
// Optional wait-for-ready watchdog is enabled by defining HX711_TIMEOUT_EN.
module hx711_multi_reader #(
  parameter int NCH         = 2,
  parameter int CLK_DIV     = 50,
  parameter int TIMEOUT_CYC = 25_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      dout,
  output logic                pd_sck,
  hx711_multi_reader_if.slave host
);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, SHIFT, GAIN, DONE} state_t;

  localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  state_t               state;
  state_t               state_next;
  logic [NCH-1:0]       dout_s1;
  logic [NCH-1:0]       dout_s2;
  logic                 rdy_q;
  logic [DW-1:0]        div_cnt;
  logic [4:0]           pulse_cnt;
  logic [4:0]           pulse_total;
  logic [NCH-1:0][23:0] shift_reg;
  logic                 fall;
  logic                 ready;
  logic                 latch_gain;
  logic                 to_hit;

  function automatic logic [4:0] pulses_for(input logic [1:0] g);
    case (g)
      2'b01:   return 5'd26;
      2'b10:   return 5'd27;
      default: return 5'd25;
    endcase
  endfunction

  // Synchronisers reset to "not ready" so a reset never looks like data-ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_s1 <= '1;
      dout_s2 <= '1;
      rdy_q   <= 1'b0;
    end else begin
      dout_s1 <= dout;
      dout_s2 <= dout_s1;
      rdy_q   <= (dout_s2 == '0);
    end
  end

  assign ready      = (dout_s2 == '0) && rdy_q;
  assign fall       = pd_sck && (div_cnt == DIV_LAST);
  assign latch_gain = host.en && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (host.en) state_next = WAIT_RDY;
      WAIT_RDY: begin
        if (ready)       state_next = SHIFT;
        else if (to_hit) state_next = IDLE;
      end
      SHIFT:    if (fall && (pulse_cnt == 5'd23)) state_next = GAIN;
      GAIN:     if (fall && ((pulse_cnt + 5'd1) == pulse_total)) state_next = DONE;
      DONE:     state_next = host.en ? WAIT_RDY : IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // div_cnt is preloaded so the first rising edge follows entry to SHIFT by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pd_sck    <= 1'b0;
      div_cnt   <= '0;
      pulse_cnt <= '0;
    end else if ((state == SHIFT) || (state == GAIN)) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        pd_sck  <= ~pd_sck;
        if (pd_sck) pulse_cnt <= pulse_cnt + 5'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end else begin
      pd_sck    <= 1'b0;
      div_cnt   <= DIV_LAST;
      pulse_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
    end else if ((state == SHIFT) && fall) begin
      for (int k = 0; k < NCH; k++) shift_reg[k] <= {shift_reg[k][22:0], dout_s2[k]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse_total   <= 5'd25;
      host.data_out <= '0;
      host.valid    <= 1'b0;
      host.busy     <= 1'b0;
    end else begin
      if (latch_gain) pulse_total <= pulses_for(host.gain_sel);
      if (state == DONE) host.data_out <= shift_reg;
      host.valid <= (state == DONE);
      host.busy  <= (state_next != IDLE);
    end
  end

`ifdef HX711_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] to_cnt;
  logic          to_flag;

  assign to_hit       = (state == WAIT_RDY) && (to_cnt == TW'(TIMEOUT_CYC - 1));
  assign host.timeout = to_flag;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (state != WAIT_RDY) to_cnt <= '0;
      else if (!to_hit)      to_cnt <= to_cnt + 1'b1;
      if (to_hit) to_flag <= 1'b1;
    end
  end
`else
  assign to_hit       = 1'b0;
  assign host.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hx711_multi_reader.sv
// Self-checking bench for hx711_multi_reader with a behavioural two-device HX711 model.
module tb_hx711_multi_reader;

  localparam int NCH         = 2;
  localparam int CLK_DIV     = 4;
  localparam int TIMEOUT_CYC = 500;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] dout;
  logic           pd_sck;

  int total = 0;
  int bad   = 0;

  logic [47:0] exp_q[$];

  int          res_pulses;
  int          res_nvalid;
  logic [47:0] res_dat;
  int          res_pre;
  int          res_lat;
  int          res_hi_min, res_hi_max, res_lo_min, res_lo_max;
  bit          res_expired;

  hx711_multi_reader_if #(.NCH(NCH)) bus ();

  hx711_multi_reader #(
    .NCH(NCH),
    .CLK_DIV(CLK_DIV),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dout(dout),
    .pd_sck(pd_sck),
    .host(bus)
  );

  always #5 clk = ~clk;

  // Device model: each rising pd_sck presents the next bit MSB first; after 24 bits DOUT idles high.
  task automatic drive_frame(input logic [23:0] v0, input logic [23:0] v1, input int ch1_lag,
                             input logic [1:0] next_gain, input int en_drop, input int rst_at);
    logic [23:0] vv [2];
    logic        prev;
    int          run;
    int          iter;
    int          tail;
    vv[0] = v0;
    vv[1] = v1;
    res_pulses = 0; res_nvalid = 0; res_dat = '0; res_pre = 0; res_lat = -1;
    res_hi_min = 1000; res_hi_max = 0; res_lo_min = 1000; res_lo_max = 0;
    res_expired = 1'b1;
    prev = pd_sck;
    dout[0] = 1'b0;
    for (int i = 0; i < ch1_lag; i++) begin
      @(posedge clk); #1;
      if (pd_sck && !prev) res_pre++;
      prev = pd_sck;
    end
    dout[1] = 1'b0;
    run = 0; iter = 0; tail = -1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      iter++;
      run++;
      if (pd_sck != prev) begin
        if (prev) begin
          if (run < res_hi_min) res_hi_min = run;
          if (run > res_hi_max) res_hi_max = run;
        end else begin
          if (res_pulses > 0) begin
            if (run < res_lo_min) res_lo_min = run;
            if (run > res_lo_max) res_lo_max = run;
          end
          res_pulses++;
          if (res_lat < 0) res_lat = iter;
          if (res_pulses == 1) bus.gain_sel = next_gain;
          if (res_pulses == en_drop) bus.en = 1'b0;
          for (int k = 0; k < NCH; k++) dout[k] = (res_pulses <= 24) ? vv[k][24-res_pulses] : 1'b1;
          if (res_pulses == rst_at) begin
            rst = 1'b0;
            #1;
            res_expired = 1'b0;
            return;
          end
        end
        run = 0;
        prev = pd_sck;
      end
      if (bus.valid) begin
        res_nvalid++;
        res_dat = bus.data_out;
        if (tail < 0) tail = 8 * CLK_DIV;
      end
      if (tail == 0) begin
        res_expired = 1'b0;
        return;
      end
      if (tail > 0) tail--;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; bus.en = 1'b0; bus.gain_sel = 2'b00; dout = '1;
    repeat (3) @(negedge clk);
    total++; if (pd_sck !== 1'b0) begin bad++; $display("[TB] FAIL reset_pd_sck: got %b want 0", pd_sck); end
    total++; if (bus.data_out !== 48'h0) begin bad++; $display("[TB] FAIL reset_data: got %h want 0", bus.data_out); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", bus.valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.timeout !== 1'b0) begin bad++; $display("[TB] FAIL reset_timeout: got %b want 0", bus.timeout); end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_gain_a128();
    logic [47:0] exp;
    bus.gain_sel = 2'b00;
    bus.en = 1'b1;
    repeat (3) @(posedge clk); #1;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL busy_rise: got %b want 1", bus.busy); end
    exp_q.push_back({24'h6869B3, 24'hB2A37A});
    drive_frame(24'hB2A37A, 24'h6869B3, 0, 2'b01, -1, -1);
    exp = exp_q.pop_front();
    total++; if (res_expired) begin bad++; $display("[TB] FAIL a128_bound: frame did not finish in budget, want finish"); end
    total++; if (res_pulses != 25) begin bad++; $display("[TB] FAIL a128_pulses: got %0d want 25", res_pulses); end
    total++; if (res_nvalid != 1) begin bad++; $display("[TB] FAIL a128_valid: got %0d strobes want 1", res_nvalid); end
    total++; if (res_dat !== exp) begin bad++; $display("[TB] FAIL a128_data: got %h want %h", res_dat, exp); end
    total++; if (res_lat != 5) begin bad++; $display("[TB] FAIL a128_latency: got %0d want 5", res_lat); end
    total++; if (res_hi_min != CLK_DIV || res_hi_max != CLK_DIV) begin bad++; $display("[TB] FAIL a128_high: got %0d..%0d want %0d", res_hi_min, res_hi_max, CLK_DIV); end
    total++; if (res_lo_min != CLK_DIV || res_lo_max != CLK_DIV) begin bad++; $display("[TB] FAIL a128_low: got %0d..%0d want %0d", res_lo_min, res_lo_max, CLK_DIV); end
  endtask

  task automatic test_gain_b32_a64();
    logic [47:0] exp;
    exp_q.push_back({24'h0467D1, 24'hFAC183});
    drive_frame(24'hFAC183, 24'h0467D1, 0, 2'b10, -1, -1);
    exp = exp_q.pop_front();
    total++; if (res_pulses != 26) begin bad++; $display("[TB] FAIL b32_pulses: got %0d want 26", res_pulses); end
    total++; if (res_nvalid != 1) begin bad++; $display("[TB] FAIL b32_valid: got %0d strobes want 1", res_nvalid); end
    total++; if (res_dat !== exp) begin bad++; $display("[TB] FAIL b32_data: got %h want %h", res_dat, exp); end
    total++; if (res_lat != 5) begin bad++; $display("[TB] FAIL b32_latency: got %0d want 5", res_lat); end
    total++; if (res_hi_min != CLK_DIV || res_hi_max != CLK_DIV || res_lo_min != CLK_DIV || res_lo_max != CLK_DIV) begin
      bad++; $display("[TB] FAIL b32_phase: high %0d..%0d low %0d..%0d want %0d", res_hi_min, res_hi_max, res_lo_min, res_lo_max, CLK_DIV);
    end
    exp_q.push_back({24'hFAC183, 24'h0467D1});
    drive_frame(24'h0467D1, 24'hFAC183, 0, 2'b00, -1, -1);
    exp = exp_q.pop_front();
    total++; if (res_pulses != 27) begin bad++; $display("[TB] FAIL a64_pulses: got %0d want 27", res_pulses); end
    total++; if (res_nvalid != 1) begin bad++; $display("[TB] FAIL a64_valid: got %0d strobes want 1", res_nvalid); end
    total++; if (res_dat !== exp) begin bad++; $display("[TB] FAIL a64_data: got %h want %h", res_dat, exp); end
    total++; if (res_hi_min != CLK_DIV || res_hi_max != CLK_DIV || res_lo_min != CLK_DIV || res_lo_max != CLK_DIV) begin
      bad++; $display("[TB] FAIL a64_phase: high %0d..%0d low %0d..%0d want %0d", res_hi_min, res_hi_max, res_lo_min, res_lo_max, CLK_DIV);
    end
  endtask

  task automatic test_slow_channel();
    logic [47:0] exp;
    exp_q.push_back({24'h800001, 24'h7FFFFE});
    drive_frame(24'h7FFFFE, 24'h800001, 1000, 2'b00, -1, -1);
    exp = exp_q.pop_front();
    total++; if (res_pre != 0) begin bad++; $display("[TB] FAIL slow_early_edges: got %0d want 0", res_pre); end
    total++; if (res_lat != 5) begin bad++; $display("[TB] FAIL slow_latency: got %0d want 5", res_lat); end
    total++; if (res_pulses != 25) begin bad++; $display("[TB] FAIL slow_pulses: got %0d want 25", res_pulses); end
    total++; if (res_dat !== exp) begin bad++; $display("[TB] FAIL slow_data: got %h want %h", res_dat, exp); end
  endtask

  task automatic test_en_drop();
    logic [47:0] exp;
    int          rises;
    logic        prev;
    exp_q.push_back({24'h6869B3, 24'hB2A37A});
    drive_frame(24'hB2A37A, 24'h6869B3, 0, 2'b00, 10, -1);
    exp = exp_q.pop_front();
    total++; if (res_pulses != 25) begin bad++; $display("[TB] FAIL endrop_pulses: got %0d want 25", res_pulses); end
    total++; if (res_nvalid != 1) begin bad++; $display("[TB] FAIL endrop_valid: got %0d strobes want 1", res_nvalid); end
    total++; if (res_dat !== exp) begin bad++; $display("[TB] FAIL endrop_data: got %h want %h", res_dat, exp); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL endrop_busy: got %b want 0", bus.busy); end
    dout = '0;
    rises = 0;
    prev = pd_sck;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (pd_sck && !prev) rises++;
      prev = pd_sck;
    end
    total++; if (rises != 0 || pd_sck !== 1'b0) begin bad++; $display("[TB] FAIL endrop_idle_sck: got %0d edges want 0", rises); end
    dout = '1;
  endtask

  task automatic test_reset_midframe();
    logic [47:0] exp;
    bus.en = 1'b1;
    repeat (3) @(posedge clk);
    drive_frame(24'h123456, 24'h654321, 0, 2'b00, -1, 12);
    total++; if (res_pulses != 12) begin bad++; $display("[TB] FAIL rst_reach: got %0d pulses want 12", res_pulses); end
    total++; if (pd_sck !== 1'b0) begin bad++; $display("[TB] FAIL rst_pd_sck: got %b want 0", pd_sck); end
    total++; if (bus.data_out !== 48'h0) begin bad++; $display("[TB] FAIL rst_data: got %h want 0", bus.data_out); end
    total++; if (bus.valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_flags: got valid=%b busy=%b want 0 0", bus.valid, bus.busy); end
    total++; if (res_nvalid != 0) begin bad++; $display("[TB] FAIL rst_no_valid: got %0d strobes want 0", res_nvalid); end
    dout = '1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    exp_q.push_back({24'hB2A37A, 24'h6869B3});
    drive_frame(24'h6869B3, 24'hB2A37A, 0, 2'b00, -1, -1);
    exp = exp_q.pop_front();
    total++; if (res_pulses != 25) begin bad++; $display("[TB] FAIL rst_next_pulses: got %0d want 25", res_pulses); end
    total++; if (res_dat !== exp) begin bad++; $display("[TB] FAIL rst_next_data: got %h want %h", res_dat, exp); end
  endtask

`ifdef HX711_TIMEOUT_EN
  task automatic test_timeout();
    logic [47:0] exp;
    int          first_to;
    int          rises;
    int          nval;
    logic        prev;
    dout = '1;
    bus.en = 1'b1;
    bus.gain_sel = 2'b00;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    first_to = -1; rises = 0; nval = 0;
    prev = pd_sck;
    for (int i = 1; i <= 700; i++) begin
      @(posedge clk); #1;
      if (bus.timeout === 1'b1 && first_to < 0) first_to = i;
      if (pd_sck && !prev) rises++;
      if (bus.valid) nval++;
      prev = pd_sck;
    end
    total++; if (first_to < 499 || first_to > 502) begin bad++; $display("[TB] FAIL to_time: got cycle %0d want 499..502", first_to); end
    total++; if (rises != 0 || nval != 0) begin bad++; $display("[TB] FAIL to_quiet: got %0d edges %0d strobes want 0 0", rises, nval); end
    exp_q.push_back({24'h6869B3, 24'hB2A37A});
    drive_frame(24'hB2A37A, 24'h6869B3, 0, 2'b00, -1, -1);
    exp = exp_q.pop_front();
    total++; if (res_dat !== exp) begin bad++; $display("[TB] FAIL to_good_data: got %h want %h", res_dat, exp); end
    total++; if (bus.timeout !== 1'b1) begin bad++; $display("[TB] FAIL to_sticky: got %b want 1", bus.timeout); end
  endtask
`else
  task automatic test_timeout();
    int   rises;
    int   nval;
    logic prev;
    dout = '1;
    bus.en = 1'b1;
    rises = 0; nval = 0;
    prev = pd_sck;
    for (int i = 0; i < 700; i++) begin
      @(posedge clk); #1;
      if (pd_sck && !prev) rises++;
      if (bus.valid) nval++;
      prev = pd_sck;
    end
    total++; if (bus.timeout !== 1'b0) begin bad++; $display("[TB] FAIL no_to_flag: got %b want 0", bus.timeout); end
    total++; if (rises != 0 || nval != 0) begin bad++; $display("[TB] FAIL no_to_quiet: got %0d edges %0d strobes want 0 0", rises, nval); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("[TB] FAIL no_to_waiting: got busy=%b want 1", bus.busy); end
  endtask
`endif

  initial begin
    test_reset();
    test_gain_a128();
    test_gain_b32_a64();
    test_slow_channel();
    test_en_drop();
    test_reset_midframe();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
